// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch) with a 2-entry valid/ready skid FIFO.
// Optional input register stage before extension: define IMM_EXT_IN_REG_EN.
module imm_extend_pipe #(
  parameter int unsigned SIZE     = 32,
  parameter int unsigned IMM_SIZE = 16,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMM_SIZE-1:0] in_imm,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIZE-1:0]     out_data,
  output logic                out_neg
);

  localparam int unsigned PAD = SIZE - IMM_SIZE;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state, state_nx;

  logic                live;
  logic                push;
  logic                pop;
  logic [IMM_SIZE-1:0] ext_imm;
  logic [1:0]          ext_mode;
  logic [SIZE-1:0]     ext_sext;
  logic [SIZE-1:0]     ext_val;
  logic                ext_neg;
  logic [SIZE-1:0]     data0;
  logic [SIZE-1:0]     data1;
  logic                neg0;
  logic                neg1;

  // Low for the cycle(s) rst_n is sampled low, so in_ready stays 0 through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

`ifdef IMM_EXT_IN_REG_EN
  logic                stg_valid;
  logic [IMM_SIZE-1:0] stg_imm;
  logic [1:0]          stg_mode;

  // The stage can take a new entry unless it is occupied and blocked by a full FIFO.
  assign in_ready = live & ~(stg_valid & (state == TWO));
  assign push     = stg_valid & (state != TWO);
  assign ext_imm  = stg_imm;
  assign ext_mode = stg_mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg_imm   <= '0;
      stg_mode  <= '0;
    end else if (in_valid && in_ready) begin
      stg_valid <= 1'b1;
      stg_imm   <= in_imm;
      stg_mode  <= in_mode;
    end else if (push) begin
      stg_valid <= 1'b0;
    end
  end
`else
  assign in_ready = live & (state != TWO);
  assign push     = in_valid & in_ready;
  assign ext_imm  = in_imm;
  assign ext_mode = in_mode;
`endif

  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;

  always_comb begin
    ext_sext = {{PAD{ext_imm[IMM_SIZE-1]}}, ext_imm};
    ext_neg  = ext_imm[IMM_SIZE-1];
    ext_val  = '0;
    case (ext_mode)
      2'b00:   ext_val = ext_sext;
      2'b01:   ext_val = {{PAD{1'b0}}, ext_imm};
      2'b10:   ext_val = {ext_imm, {PAD{1'b0}}};
      default: ext_val = ext_sext << BR_SHIFT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = TWO;
        else if (pop && !push) state_nx = EMPTY;
      end
      TWO:     if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // data0 is always the head; data1 only holds the second entry while in TWO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
      neg0  <= 1'b0;
      neg1  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            data0 <= ext_val;
            neg0  <= ext_neg;
          end
        end
        ONE: begin
          if (push && pop) begin
            data0 <= ext_val;
            neg0  <= ext_neg;
          end else if (push) begin
            data1 <= ext_val;
            neg1  <= ext_neg;
          end
        end
        TWO: begin
          if (pop) begin
            data0 <= data1;
            neg0  <= neg1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = data0;
  assign out_neg  = neg0;

endmodule
